// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel driver: display mode encoding (also used by
// the mode/key control logic) and a width helper for parameter-derived counters.
package led_panel_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_SCROLL_L = 2'b01,
        MODE_SCROLL_R = 2'b10,
        MODE_BLINK    = 2'b11
    } mode_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Column scan timebase: a prescaler that ticks once every SCAN_DIV clocks and a
// column counter that advances on each tick and flags the end of a frame.
module scan_timer
    import led_panel_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int COLS     = 7,
    parameter int CW       = bits_for(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          scan_tick,
    output logic [CW-1:0] col_idx,
    output logic          frame_wrap
);

    localparam int PW = bits_for(SCAN_DIV);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [CW-1:0] col_idx_q, col_idx_d;

    always_comb begin
        scan_tick   = (prescaler_q == PW'(SCAN_DIV - 1));
        frame_wrap  = scan_tick && (col_idx_q == CW'(COLS - 1));
        prescaler_d = scan_tick ? '0 : prescaler_q + 1'b1;
        col_idx_d   = col_idx_q;
        if (scan_tick) begin
            col_idx_d = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            col_idx_q   <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            col_idx_q   <= col_idx_d;
        end
    end

    assign col_idx = col_idx_q;

endmodule

// File: rtl/led_matrix_scroller.sv
// Column-scanned LED matrix driver with a message buffer and static/scroll/blink modes.
// Define BLINK_EN to build the blink mode; otherwise mode 2'b11 behaves as static.
module led_matrix_scroller
    import led_panel_pkg::*;
#(
    parameter int ROWS          = 5,
    parameter int COLS          = 7,
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 1000,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [ROWS-1:0]            wr_data,
    output logic [ROWS-1:0]            row,
    output logic [COLS-1:0]            col_n,
    output logic                       frame_done
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = bits_for(COLS);
    localparam int FW = bits_for(SCROLL_FRAMES);

    logic          scan_tick;
    logic          frame_wrap;
    logic [CW-1:0] col_idx;

    mode_t         req_mode;
    mode_t         state_q, state_d;
    logic [AW-1:0] offset_q, offset_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          visible;

    logic [ROWS-1:0] msg_mem_q [MSG_LEN];
    logic [ROWS-1:0] msg_mem_d [MSG_LEN];

    logic            blank_q, blank_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [COLS-1:0] col_n_q, col_n_d;
    logic            frame_done_q, frame_done_d;

    int              rd_sum;
    logic [AW-1:0]   rd_idx;
    logic [ROWS-1:0] pixel;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .COLS     (COLS),
        .CW       (CW)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_tick  (scan_tick),
        .col_idx    (col_idx),
        .frame_wrap (frame_wrap)
    );

`ifdef BLINK_EN
    logic visible_q, visible_d;
    assign visible = visible_q;
`else
    assign visible = 1'b1;
`endif

    always_comb begin
`ifdef BLINK_EN
        req_mode = mode_t'(mode);
`else
        req_mode = (mode == MODE_BLINK) ? MODE_STATIC : mode_t'(mode);
`endif
    end

    // Mode and window updates happen only on the frame wrap, so a frame never tears;
    // a mode change at that wrap takes priority over any pending step.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
`ifdef BLINK_EN
        visible_d   = visible_q;
`endif
        if (frame_wrap) begin
            if (req_mode != state_q) begin
                state_d     = req_mode;
                frame_cnt_d = '0;
`ifdef BLINK_EN
                visible_d   = 1'b1;
`endif
                if (req_mode == MODE_STATIC) begin
                    offset_d = '0;
                end
            end else if (frame_cnt_q == FW'(SCROLL_FRAMES - 1)) begin
                frame_cnt_d = '0;
                case (state_q)
                    MODE_SCROLL_L: offset_d = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
                    MODE_SCROLL_R: offset_d = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - 1'b1;
`ifdef BLINK_EN
                    MODE_BLINK:    visible_d = ~visible_q;
`endif
                    default:       offset_d = offset_q;
                endcase
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        msg_mem_d = msg_mem_q;
        if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN))) begin
            msg_mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        rd_sum = int'(offset_q) + int'(col_idx);
        if (rd_sum >= MSG_LEN) begin
            rd_sum = rd_sum - MSG_LEN;
        end
        rd_idx = AW'(rd_sum);
        pixel  = visible ? msg_mem_q[rd_idx] : '0;
    end

    // One dark cycle after every tick keeps the previous column's data from ghosting
    // onto the next; the pixel is then latched and held for the rest of the slot.
    always_comb begin
        row_d        = row_q;
        col_n_d      = col_n_q;
        blank_d      = scan_tick;
        frame_done_d = frame_wrap;
        if (scan_tick) begin
            row_d   = '0;
            col_n_d = '1;
        end else if (blank_q) begin
            row_d   = pixel;
            col_n_d = ~(COLS'(1) << col_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MODE_STATIC;
            offset_q     <= '0;
            frame_cnt_q  <= '0;
            blank_q      <= 1'b0;
            row_q        <= '0;
            col_n_q      <= '1;
            frame_done_q <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            frame_cnt_q  <= frame_cnt_d;
            blank_q      <= blank_d;
            row_q        <= row_d;
            col_n_q      <= col_n_d;
            frame_done_q <= frame_done_d;
            msg_mem_q    <= msg_mem_d;
        end
    end

`ifdef BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            visible_q <= 1'b1;
        end else begin
            visible_q <= visible_d;
        end
    end
`endif

    assign row        = row_q;
    assign col_n      = col_n_q;
    assign frame_done = frame_done_q;

endmodule
